// File: rtl/serial_adder_if.sv
// serial_adder_if: operand and result valid/ready bundle for serial_adder.
// Overflow is present only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic             Overflow;

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Carry, busy, Overflow
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Carry, busy, Overflow
  );
`else
  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Carry, busy
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Carry, busy
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock, built from half_adder cells.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement Overflow output.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding one bit per clock, busy high
// DONE  | result presented, waiting for out_ready
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             c_q;
  logic             carry_q;
  logic             s0;
  logic             c0;
  logic             s_bit;
  logic             c1;
  logic             cout;
  logic             accept;
  logic             last;

  half_adder u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(s0),    .c(c0));
  half_adder u_ha1 (.a(s0),      .b(c_q),     .s(s_bit), .c(c1));
  assign cout = c0 | c1;

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign res_nxt = WIDTH'({s_bit, res_sh} >> 1);

  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = 1'b1;
      RUN:     bus.busy      = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      c_q     <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      a_sh   <= bus.A;
      b_sh   <= bus.B;
      c_q    <= bus.Cin;
      res_sh <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      c_q    <= cout;
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum_q   <= res_nxt;
        carry_q <= cout;
      end
    end
  end

  assign bus.Sum   = sum_q;
  assign bus.Carry = carry_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // On the last bit c_q is the carry into the MSB and cout the carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ovf_q <= 1'b0;
    else if (last) ovf_q <= c_q ^ cout;
  end

  assign bus.Overflow = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table vectors, hand sequences and a random sweep at WIDTH 1, 8 and 32,
// with per-instance scoreboards fed at operand acceptance and drained at result handshake.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n1    = 0;
  int n8    = 0;
  int n32   = 0;

  serial_adder_if #(.WIDTH(1))  if1 ();
  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(32)) if32 ();

  serial_adder #(.WIDTH(1))  u1  (.clk(clk), .rst(rst), .bus(if1));
  serial_adder #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8));
  serial_adder #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(if32));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  vec_t vecs [8];

  logic [7:0] bb_a [4];
  logic [7:0] bb_b [4];

  logic [1:0]  q1  [$];
  logic [8:0]  q8  [$];
  logic [32:0] q32 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      q8.delete();
      q32.delete();
    end else begin
      if (if1.in_valid && if1.in_ready)
        q1.push_back({1'b0, if1.A} + {1'b0, if1.B} + 2'(if1.Cin));
      if (if8.in_valid && if8.in_ready)
        q8.push_back({1'b0, if8.A} + {1'b0, if8.B} + 9'(if8.Cin));
      if (if32.in_valid && if32.in_ready)
        q32.push_back({1'b0, if32.A} + {1'b0, if32.B} + 33'(if32.Cin));

      if (if1.out_valid && if1.out_ready) begin
        n1++;
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL sb1 unexpected result got %0h", {if1.Carry, if1.Sum});
        end else check("sb1", {if1.Carry, if1.Sum}, q1.pop_front());
      end
      if (if8.out_valid && if8.out_ready) begin
        n8++;
        if (q8.size() == 0) begin
          total++; bad++;
          $display("FAIL sb8 unexpected result got %0h", {if8.Carry, if8.Sum});
        end else check("sb8", {if8.Carry, if8.Sum}, q8.pop_front());
      end
      if (if32.out_valid && if32.out_ready) begin
        n32++;
        if (q32.size() == 0) begin
          total++; bad++;
          $display("FAIL sb32 unexpected result got %0h", {if32.Carry, if32.Sum});
        end else check("sb32", {if32.Carry, if32.Sum}, q32.pop_front());
      end
    end
  end

  // Drive one operand set into the WIDTH=8 instance; returns edges from accept to out_valid.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, output int lat);
    @(posedge clk); #1;
    check("in_ready before accept", if8.in_ready, 1);
    if8.A = a; if8.B = b; if8.Cin = cin; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    if8.A = ~a; if8.B = 8'h5A; if8.Cin = ~cin;
    lat = 0;
    while (!if8.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release8();
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    int r;
    int busycnt;
    int seen;
    int rise [4];
    logic prev_busy;
    logic prev_ov;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0};
    bb_a = '{8'h11, 8'hF0, 8'h80, 8'h01};
    bb_b = '{8'h22, 8'h20, 8'h7F, 8'hFE};

    if1.in_valid = 0;  if1.A = '0;  if1.B = '0;  if1.Cin = 0;  if1.out_ready = 0;
    if8.in_valid = 0;  if8.A = '0;  if8.B = '0;  if8.Cin = 0;  if8.out_ready = 0;
    if32.in_valid = 0; if32.A = '0; if32.B = '0; if32.Cin = 0; if32.out_ready = 0;

    #2;
    check("reset in_ready", if8.in_ready, 1);
    check("reset out_valid", if8.out_valid, 0);
    check("reset busy", if8.busy, 0);
    check("reset Sum", if8.Sum, 0);
    check("reset Carry", if8.Carry, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset Overflow", if8.Overflow, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check("latency", lat, 8);
      check("vec Sum", if8.Sum, vecs[i].sum);
      check("vec Carry", if8.Carry, vecs[i].carry);
      check("done busy", if8.busy, 0);
      check("done in_ready", if8.in_ready, 0);
`ifdef SERIAL_ADDER_OVF_EN
      check("vec Overflow", if8.Overflow, vecs[i].ovf);
`endif
      release8();
      check("out_valid after handshake", if8.out_valid, 0);
    end

    // Asynchronous reset in the middle of RUN.
    @(posedge clk); #1;
    if8.A = 8'hAA; if8.B = 8'h55; if8.Cin = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun reset out_valid", if8.out_valid, 0);
    check("midrun reset busy", if8.busy, 0);
    check("midrun reset in_ready", if8.in_ready, 1);
    check("midrun reset Sum", if8.Sum, 0);
    check("midrun reset Carry", if8.Carry, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    if8.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (if8.out_valid || if8.busy) seen++;
    end
    if8.out_ready = 1'b0;
    check("no result after reset", seen, 0);

    // Backpressure with new operands waiting.
    op8(8'h0F, 8'h01, 1'b0, lat);
    check("bp latency", lat, 8);
    if8.A = 8'h12; if8.B = 8'h34; if8.Cin = 1'b0; if8.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp out_valid", if8.out_valid, 1);
      check("bp in_ready", if8.in_ready, 0);
      check("bp Sum", if8.Sum, 8'h10);
      check("bp Carry", if8.Carry, 0);
    end
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    check("bp idle out_valid", if8.out_valid, 0);
    check("bp idle in_ready", if8.in_ready, 1);
    @(posedge clk); #1;
    check("bp accept busy", if8.busy, 1);
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp second latency", lat, 8);
    check("bp second Sum", if8.Sum, 8'h46);
    check("bp second Carry", if8.Carry, 0);
    release8();

    // Back-to-back with in_valid and out_ready held high.
    @(posedge clk); #1;
    if8.A = bb_a[0]; if8.B = bb_b[0]; if8.Cin = 1'b0;
    if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    k = 0; r = 0; busycnt = 0; prev_busy = 1'b0; prev_ov = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (if8.busy && !prev_busy) begin
        k++;
        if (k < 4) begin
          if8.A = bb_a[k]; if8.B = bb_b[k]; if8.Cin = k[0];
        end else if8.in_valid = 1'b0;
      end
      if (if8.out_valid && !prev_ov && r < 4) begin
        rise[r] = c;
        r++;
      end
      if (if8.busy) busycnt++;
      prev_busy = if8.busy;
      prev_ov   = if8.out_valid;
    end
    if8.out_ready = 1'b0;
    check("b2b results", r, 4);
    for (int i = 1; i < 4; i++)
      if (i < r) check("b2b spacing", rise[i] - rise[i-1], 10);
    check("b2b busy cycles", busycnt, 32);

    // WIDTH=1 single-bit case.
    @(posedge clk); #1;
    if1.A = 1'b1; if1.B = 1'b1; if1.Cin = 1'b1; if1.in_valid = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    lat = 0;
    while (!if1.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w1 latency", lat, 1);
    check("w1 Sum", if1.Sum, 1);
    check("w1 Carry", if1.Carry, 1);
    if1.out_ready = 1'b1;
    @(posedge clk); #1;
    if1.out_ready = 1'b0;

    // Random sweep, operands changing every cycle on all three widths.
    n1 = 0; n8 = 0; n32 = 0;
    if1.in_valid = 1; if8.in_valid = 1; if32.in_valid = 1;
    if1.out_ready = 1; if8.out_ready = 1; if32.out_ready = 1;
    for (int c = 0; c < 400; c++) begin
      if1.A  = 1'($urandom());  if1.B  = 1'($urandom());  if1.Cin  = 1'($urandom());
      if8.A  = 8'($urandom());  if8.B  = 8'($urandom());  if8.Cin  = 1'($urandom());
      if32.A = $urandom();      if32.B = $urandom();      if32.Cin = 1'($urandom());
      @(posedge clk); #1;
    end
    if1.in_valid = 0; if8.in_valid = 0; if32.in_valid = 0;
    repeat (40) @(posedge clk);
    #1;
    if1.out_ready = 0; if8.out_ready = 0; if32.out_ready = 0;
    check("w1 drained", q1.size(), 0);
    check("w8 drained", q8.size(), 0);
    check("w32 drained", q32.size(), 0);
    check("w1 result count", n1 >= 120, 1);
    check("w8 result count", n8 >= 35, 1);
    check("w32 result count", n32 >= 10, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
